jtag_uart_rx_deframer: RTL and testbench

Downstream consumer of the virtual-JTAG serial RX line. Takes the raw asynchronous serial bit (8N1, LSB first, idle high) and resynchronises it into the system clock domain. Recovers bytes by mid-bit sampling and buffers them in a small FIFO. Presents the bytes to the fabric on a valid/ready stream with sticky error status.

---
 rtl/jtag_uart_pkg.sv | 22 ++
 rtl/jtag_uart_rx_fifo.sv | 59 +++++
 rtl/jtag_uart_rx_deframer.sv | 162 ++++++++++++++++
 tb/tb_jtag_uart_rx_deframer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_uart_pkg.sv
// jtag_uart_pkg: shared types, constants and helpers for the JTAG UART RX deframer
package jtag_uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Clocks from the start edge to the middle of the start bit
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/jtag_uart_rx_fifo.sv
// jtag_uart_rx_fifo: show-ahead byte FIFO with registered head output and drop-on-full
module jtag_uart_rx_fifo
    import jtag_uart_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic [AW:0]          count,
    output logic                 drop
);

    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic                 empty, full, pop_ok, push_ok;

    // Pointer arithmetic; a pop frees the slot a simultaneous push into a full FIFO needs
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = ((wr_q - rd_q) == (AW+1)'(DEPTH));
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && !push_ok;
        wr_d    = wr_q + (AW+1)'(push_ok);
        rd_d    = rd_q + (AW+1)'(pop_ok);
        dout_d  = (push_ok && (rd_d == wr_q)) ? din :
                  pop_ok                      ? mem_q[rd_d[AW-1:0]] : dout_q;
    end

    // Pointer and head-register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            dout_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            dout_q <= dout_d;
        end
    end

    // Storage array, written only when the push is accepted
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign dout  = dout_q;
    assign valid = !empty;
    assign count = wr_q - rd_q;

endmodule

// File: rtl/jtag_uart_rx_deframer.sv
// jtag_uart_rx_deframer: 8N1 serial RX (8E1 when JTAG_UART_RX_PARITY_EN is defined) into a byte FIFO stream
module jtag_uart_rx_deframer
    import jtag_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_in,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clear_err
`ifdef JTAG_UART_RX_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam int             BW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [BW-1:0]  BIT_MAX   = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 rx_s, push, fe_set, drop;
`ifdef JTAG_UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, parity_err_q, parity_err_d, pe_set;
`endif

    assign rx_s = sync_q[1];

    // Frame FSM: mid-bit sampling, byte assembly and error detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_set  = 1'b0;
`ifdef JTAG_UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe_set    = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = '0;
                bit_d   = '0;
`ifdef JTAG_UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end else cnt_d = cnt_q + CW'(1);
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + BW'(1);
`ifdef JTAG_UART_RX_PARITY_EN
                if (bit_q == BIT_MAX) state_d = PARITY;
`else
                if (bit_q == BIT_MAX) state_d = STOP;
`endif
            end else cnt_d = cnt_q + CW'(1);
`ifdef JTAG_UART_RX_PARITY_EN
            PARITY: if (cnt_q == BIT_LAST) begin
                cnt_d     = '0;
                par_bad_d = rx_s ^ (^shift_q);
                pe_set    = rx_s ^ (^shift_q);
                state_d   = STOP;
            end else cnt_d = cnt_q + CW'(1);
`endif
            STOP: if (cnt_q == BIT_LAST) begin
                cnt_d = '0;
                if (rx_s) begin
`ifdef JTAG_UART_RX_PARITY_EN
                    push = !par_bad_q;
`else
                    push = 1'b1;
`endif
                    state_d = IDLE;
                end else begin
                    fe_set  = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end else cnt_d = cnt_q + CW'(1);
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser input and sticky flags; a set in the same cycle as clear_err wins
    always_comb begin
        sync_d      = {sync_q[0], rx_in};
        frame_err_d = fe_set | (frame_err_q & ~clear_err);
        overrun_d   = drop | (overrun_q & ~clear_err);
`ifdef JTAG_UART_RX_PARITY_EN
        parity_err_d = pe_set | (parity_err_q & ~clear_err);
`endif
    end

    // All control state; synchroniser presets to the idle line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef JTAG_UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef JTAG_UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    jtag_uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shift_q),
        .pop   (m_ready),
        .dout  (m_data),
        .valid (m_valid),
        .count (fifo_count),
        .drop  (drop)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef JTAG_UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_jtag_uart_rx_deframer.sv
// tb_jtag_uart_rx_deframer: randomized self-checking bench for the RX deframer
module tb_jtag_uart_rx_deframer;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef JTAG_UART_RX_PARITY_EN
    localparam int LAT = 2 + 10 * CPB + CPB / 2 + 1;
`else
    localparam int LAT = 2 + 9 * CPB + CPB / 2 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, rx_in, m_ready, clear_err;
    logic [7:0] m_data;
    logic       m_valid, frame_err, overrun;
    logic [2:0] fifo_count;
`ifdef JTAG_UART_RX_PARITY_EN
    logic       parity_err;
    logic       bad_parity = 1'b0;
`endif

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc;
    logic [7:0]  got[$];
    int unsigned got_cyc[$];

    jtag_uart_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clear_err  (clear_err)
`ifdef JTAG_UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted byte with the cycle it was presented
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            got.push_back(m_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; stop=0 produces a framing error
    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(CPB);
        end
`ifdef JTAG_UART_RX_PARITY_EN
        rx_in = (^b) ^ bad_parity;
        tick(CPB);
`endif
        rx_in = stop;
        tick(CPB);
        rx_in = 1'b1;
        tick(4);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_in = 1'b1; m_ready = 1'b0; clear_err = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            rx_in = 1'($urandom);
            tick(1);
        end
        rx_in = 1'b1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
`ifdef JTAG_UART_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
`endif
        rst_n = 1'b1;
        tick(4);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_single();
        int lat;
        m_ready = 1'b1;
        got.delete(); got_cyc.delete();
        send_frame(8'hA5, 1'b1);
        tick(4);
        checks++;
        if (got.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d bytes want 1", got.size());
        end else begin
            lat = int'(got_cyc[0] - start_cyc);
            checks++; if (got[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", got[0]); end
            checks++; if (lat < LAT - 4 || lat > LAT + 4) begin errors++; $display("FAIL single_latency: got %0d want about %0d", lat, LAT); end
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b want 0", m_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL single_flags: got fe=%b ov=%b want 0 0", frame_err, overrun); end
    endtask

    task automatic test_glitch();
        got.delete();
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(3 * CPB);
        checks++; if (got.size() != 0) begin errors++; $display("FAIL glitch_bytes: got %0d want 0", got.size()); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_frame_err();
        got.delete();
        send_frame(8'h3C, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ferr_count: got %0d want 0", fifo_count); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL ferr_bytes: got %0d want 0", got.size()); end
        pulse_clear();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
        send_frame(8'h55, 1'b1);
        tick(2);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h55) begin
            errors++; $display("FAIL ferr_next_byte: got n=%0d first=%h want 1 byte 55", got.size(), got.size() ? got[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       stop, exp_fe;
        got.delete();
        exp_fe = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if (stop) exp_q.push_back(b);
            else exp_fe = 1'b1;
            send_frame(b, stop);
        end
        tick(2);
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (frame_err !== exp_fe) begin errors++; $display("FAIL rand_frame_err: got %b want %b", frame_err, exp_fe); end
        pulse_clear();
    endtask

    task automatic test_overrun();
        logic [7:0] sent[$];
        logic [7:0] model[$];
        logic       exp_ov;
        logic [7:0] b;
        got.delete();
        m_ready = 1'b0;
        exp_ov = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom);
            sent.push_back(b);
            if (model.size() < DEPTH) model.push_back(b);
            else exp_ov = 1'b1;
            send_frame(b, 1'b1);
        end
        checks++; if (fifo_count !== 3'(model.size())) begin errors++; $display("FAIL ovr_count: got %0d want %0d", fifo_count, model.size()); end
        checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL ovr_flag: got %b want %b", overrun, exp_ov); end
        checks++; if (m_data !== model[0] || m_valid !== 1'b1) begin errors++; $display("FAIL ovr_head: got v=%b d=%h want 1 %h", m_valid, m_data, model[0]); end
        tick(7);
        checks++; if (m_data !== model[0]) begin errors++; $display("FAIL ovr_stable: got %h want %h", m_data, model[0]); end
        m_ready = 1'b1;
        for (int t = 0; t < 20 && fifo_count != 0; t++) tick(1);
        tick(1);
        checks++; if (got.size() != model.size()) begin errors++; $display("FAIL ovr_drain_count: got %0d want %0d", got.size(), model.size()); end
        for (int i = 0; i < model.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== model[i]) begin errors++; $display("FAIL ovr_drain[%0d]: got %h want %h", i, got[i], model[i]); end
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovr_empty: got %0d want 0", fifo_count); end
        pulse_clear();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_reset_mid();
        got.delete();
        m_ready = 1'b1;
        rx_in = 1'b0;
        tick(CPB);
        rx_in = 1'b1;
        tick(3 * CPB + CPB / 2);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_in = 1'($urandom);
            tick(1);
        end
        rx_in = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(4 * CPB);
        send_frame(8'h81, 1'b1);
        tick(2);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h81) begin
            errors++; $display("FAIL mid_reset_bytes: got n=%0d first=%h want 1 byte 81", got.size(), got.size() ? got[0] : 8'h00);
        end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got fe=%b ov=%b want 0 0", frame_err, overrun); end
    endtask

`ifdef JTAG_UART_RX_PARITY_EN
    task automatic test_parity();
        got.delete();
        bad_parity = 1'b0;
        send_frame(8'h07, 1'b1);
        tick(2);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h07) begin
            errors++; $display("FAIL par_good: got n=%0d want 1 byte 07", got.size());
        end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", parity_err); end
        got.delete();
        bad_parity = 1'b1;
        send_frame(8'h07, 1'b1);
        bad_parity = 1'b0;
        tick(2);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", parity_err); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL par_bad_bytes: got %0d want 0", got.size()); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_frame_err: got %b want 0", frame_err); end
        pulse_clear();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_random();
        test_overrun();
        test_reset_mid();
`ifdef JTAG_UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
